// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode definitions
package alu_pkg;

  typedef enum logic [2:0] {
    ADD          = 3'd0,
    SUBTR        = 3'd1,
    MUL          = 3'd2,
    ARTH_SHIFT_R = 3'd3,
    SHIFT_L      = 3'd4,
    SHIFT_R      = 3'd5
  } operator_t;

  localparam logic [2:0] OP_LAST = 3'd5;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_sat_counter.sv
// rtl/alu_sat_counter.sv - saturating event counter
module alu_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered issue/retire wrapper around the combinational ALU
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int CNT_WIDTH = 16,
  localparam int OUT_WIDTH = WIDTH * 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     num_1,
  input  logic [WIDTH-1:0]     num_2,
  input  logic [2:0]           op_select,
  output logic [WIDTH-1:0]     alu_num_1,
  output logic [WIDTH-1:0]     alu_num_2,
  output logic [2:0]           alu_op_select,
  input  logic [OUT_WIDTH-1:0] alu_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_result,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  // ready_en_q keeps in_ready low in the cycle right after reset
  logic                 ready_en_q;
  logic                 a_valid_q, a_valid_d;
  logic [WIDTH-1:0]     a_num1_q, a_num1_d;
  logic [WIDTH-1:0]     a_num2_q, a_num2_d;
  logic [2:0]           a_op_q, a_op_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_result_q, out_result_d;
  logic                 out_err_q, out_err_d;
  logic                 b_free, a_adv, in_xfer, a_err;

  always_comb begin
    b_free       = !out_valid_q || out_ready;
    a_adv        = a_valid_q && b_free;
    in_ready     = ready_en_q && (!a_valid_q || a_adv);
    in_xfer      = in_valid && in_ready;
    a_err        = is_illegal_op(a_op_q);
    a_valid_d    = a_valid_q;
    a_num1_d     = a_num1_q;
    a_num2_d     = a_num2_q;
    a_op_d       = a_op_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    if (in_xfer) begin
      a_valid_d = 1'b1;
      a_num1_d  = num_1;
      a_num2_d  = num_2;
      a_op_d    = op_select;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end
    if (a_adv) begin
      out_valid_d  = 1'b1;
      out_result_d = a_err ? '0 : alu_result;
      out_err_d    = a_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en_q   <= 1'b0;
      a_valid_q    <= 1'b0;
      a_num1_q     <= '0;
      a_num2_q     <= '0;
      a_op_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      a_valid_q    <= a_valid_d;
      a_num1_q     <= a_num1_d;
      a_num2_q     <= a_num2_d;
      a_op_q       <= a_op_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  assign alu_num_1     = a_num1_q;
  assign alu_num_2     = a_num2_q;
  assign alu_op_select = a_op_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_err       = out_err_q;

  alu_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_op_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_xfer),
    .count (op_count)
  );

  alu_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_xfer && is_illegal_op(op_select)),
    .count (err_count)
  );

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  num_1, num_2;
  logic [2:0]  op_select;
  logic [7:0]  alu_num_1, alu_num_2;
  logic [2:0]  alu_op_select;
  logic [15:0] alu_result;
  logic        out_valid, out_ready, out_err;
  logic [15:0] out_result, op_count, err_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_err;
  logic [7:0]  s_alu_num_1, s_alu_num_2;
  logic [2:0]  s_alu_op_select;
  logic [15:0] s_out_result;
  logic [3:0]  s_op_count, s_err_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_res_q[$];
  logic        exp_err_q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [15:0] r;
    case (op)
      3'd0: r = {8'd0, a} + {8'd0, b};
      3'd1: r = {8'd0, a} - {8'd0, b};
      3'd2: r = {8'd0, a} * {8'd0, b};
      3'd3: r = $signed({{8{a[7]}}, a}) >>> b;
      3'd4: r = {8'd0, a} << b;
      3'd5: r = {8'd0, a} >> b;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // attached ALU returns garbage on illegal opcodes so the forced zero is observable
  always_comb alu_result = (alu_op_select > 3'd5) ? 16'hDEAD : model(alu_num_1, alu_num_2, alu_op_select);

  alu_issue_stage #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num_1(num_1), .num_2(num_2), .op_select(op_select),
    .alu_num_1(alu_num_1), .alu_num_2(alu_num_2), .alu_op_select(alu_op_select),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .op_count(op_count), .err_count(err_count)
  );

  alu_issue_stage #(.WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .num_1(8'd1), .num_2(8'd1), .op_select(3'd0),
    .alu_num_1(s_alu_num_1), .alu_num_2(s_alu_num_2), .alu_op_select(s_alu_op_select),
    .alu_result(16'h0000), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_result(s_out_result), .out_err(s_out_err), .op_count(s_op_count), .err_count(s_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = v; num_1 = a; num_2 = b; op_select = op;
  endtask

  // one clock: record transfers just before the edge, return 1 ns after it
  task automatic step(output bit acc);
    logic [15:0] er;
    logic        ee;
    #1;
    acc = in_valid && in_ready;
    if (acc) begin
      exp_res_q.push_back(model(num_1, num_2, op_select));
      exp_err_q.push_back(op_select > 3'd5);
    end
    if (out_valid && out_ready) begin
      chk("sb_not_empty", {31'd0, exp_res_q.size() != 0}, 32'd1);
      if (exp_res_q.size() != 0) begin
        er = exp_res_q.pop_front();
        ee = exp_err_q.pop_front();
        chk("sb_result", {16'd0, out_result}, {16'd0, er});
        chk("sb_err", {31'd0, out_err}, {31'd0, ee});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    drive(1'b0, 8'd0, 8'd0, 3'd0);
    for (int i = 0; i < 10 && (exp_res_q.size() != 0 || out_valid); i++) step(acc);
    chk("drain_empty", {31'd0, exp_res_q.size() == 0 && !out_valid}, 32'd1);
  endtask

  initial begin : main
    bit          acc;
    int          idx, nacc, s_acc;
    logic [15:0] held;
    bit          held_v;
    logic [7:0]  ca [4] = '{8'd10, 8'd50, 8'h80, 8'd9};
    logic [7:0]  cb [4] = '{8'd20, 8'd3, 8'd2, 8'd9};
    logic [2:0]  cop[4] = '{3'd0, 3'd5, 3'd3, 3'd2};

    rst = 1'b1; out_ready = 1'b1; s_in_valid = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 3'd0);
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {out_result, op_count}, 32'd0);
    chk("rst_alu_ops", {13'd0, alu_num_1, alu_num_2, alu_op_select}, 32'd0);
    rst = 1'b0;
    step(acc);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // single ADD: result visible two edges after acceptance
    drive(1'b1, 8'd200, 8'd100, ADD);
    step(acc);
    drive(1'b0, 8'd0, 8'd0, 3'd0);
    chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    step(acc);
    chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
    chk("add_result", {16'd0, out_result}, 32'h012C);
    chk("add_err", {31'd0, out_err}, 32'd0);
    chk("add_op_count", {16'd0, op_count}, 32'd1);
    drain();

    // back-to-back commands
    drive(1'b1, 8'd255, 8'd255, MUL);   step(acc); chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'd5, 8'd7, SUBTR);     step(acc); chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
    chk("b2b_mul", {16'd0, out_result}, 32'hFE01);
    drive(1'b1, 8'd1, 8'd3, SHIFT_L);   step(acc); chk("b2b_ready2", {31'd0, in_ready}, 32'd1);
    chk("b2b_sub", {16'd0, out_result}, 32'hFFFE);
    drive(1'b0, 8'd0, 8'd0, 3'd0);      step(acc);
    chk("b2b_shl", {16'd0, out_result}, 32'h0008);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // back-pressure for five cycles while streaming
    out_ready = 1'b0; idx = 0; nacc = 0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, ca[idx], cb[idx], cop[idx]);
      step(acc);
      if (acc) begin idx++; nacc++; end
      if (out_valid) begin
        if (!held_v) begin held = out_result; held_v = 1'b1; end
        else chk("stall_stable", {16'd0, out_result}, {16'd0, held});
      end
    end
    chk("stall_accepts", nacc, 32'd2);
    chk("stall_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      drive(1'b1, ca[idx], cb[idx], cop[idx]);
      step(acc);
      if (acc) idx++;
    end
    chk("stall_all_sent", idx, 32'd4);
    drain();

    // illegal opcode then a legal one
    drive(1'b1, 8'd3, 8'd4, 3'd7); step(acc);
    drive(1'b1, 8'd3, 8'd4, ADD);  step(acc);
    drive(1'b0, 8'd0, 8'd0, 3'd0);
    chk("ill_result", {16'd0, out_result}, 32'd0);
    chk("ill_err", {31'd0, out_err}, 32'd1);
    chk("ill_err_count", {16'd0, err_count}, 32'd1);
    step(acc);
    chk("post_ill_result", {16'd0, out_result}, 32'h0007);
    chk("post_ill_err", {31'd0, out_err}, 32'd0);
    drain();

    // reset with both stages occupied
    out_ready = 1'b0;
    drive(1'b1, 8'd11, 8'd22, ADD); step(acc); chk("fill_a", {31'd0, acc}, 32'd1);
    drive(1'b1, 8'd33, 8'd44, ADD); step(acc); chk("fill_b", {31'd0, acc}, 32'd1);
    drive(1'b0, 8'd0, 8'd0, 3'd0);
    rst = 1'b1;
    step(acc);
    exp_res_q.delete(); exp_err_q.delete();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_counts", {op_count, err_count}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(acc);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // saturation on a 4-bit counter instance
    s_acc = 0;
    for (int c = 0; c < 40 && s_acc < 20; c++) begin
      s_in_valid = 1'b1;
      #1;
      if (s_in_ready) s_acc++;
      @(posedge clk); #1;
      if (s_acc == 15) chk("sat_reach", {28'd0, s_op_count}, 32'd15);
    end
    s_in_valid = 1'b0;
    chk("sat_sent", s_acc, 32'd20);
    chk("sat_hold", {28'd0, s_op_count}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
